clk_int_div_tick: RTL
=====================

Name: clk_int_div_tick

Overview:
- Runtime-programmable integer prescaler that sits directly upstream of the APB timer counter.
- Divides the peripheral clock by a software-written divisor.
- Outputs a single-cycle tick enable plus a registered divided clock.
- Reports through a valid/ready/done handshake when a new divisor is safe to use.
- Divisor changes take effect only on a period boundary, so the downstream counter never sees a runt period.

Parameters:
DIV_WIDTH, 20, width of divisor and internal counter
DEF_DIV, 2, divisor in effect after reset (must be >= 2)

Ports:
clk_i  input  1  peripheral clock
rst_n_i  input  1  synchronous active-low reset
en_i  input  1  count enable; 0 holds the divider idle
div_i  input  DIV_WIDTH  requested divisor
div_valid_i  input  1  div_i valid request
div_ready_o  output  1  block can accept div_i this cycle
div_done_o  output  1  last accepted divisor is in effect
tick_o  output  1  one-cycle pulse, once per divided period
clk_o  output  1  registered divided clock
cnt_o  output  DIV_WIDTH  current phase counter (debug/readback)

Behaviour:
- Reset is synchronous: applied on a clk_i edge with rst_n_i=0. It overrides everything, including a mid-change state.
- Reset values:
  - state=RUN, div_q=DEF_DIV, pend_q=DEF_DIV, cnt_q=0.
  - tick_o=0, clk_o=0, div_ready_o=1, div_done_o=1.
- Divisor rules:
  - Effective divisor D = div_q. An accepted div_i below 2 (0 or 1) is clamped to 2 when latched.
  - All arithmetic is unsigned, DIV_WIDTH wide. D=2^DIV_WIDTH-1 is legal.
- Counting:
  - When en_i=1: cnt_q steps 0,1,...,D-1,0,...
  - When en_i=0: cnt_q goes to 0 on the next edge and stays there. tick_o=0 and clk_o=0 while cnt is held.
- tick_o: registered; high for exactly one cycle whenever cnt_q==D-1 and the divider was enabled on the edge that produced that count. Exactly one tick every D cycles.
- clk_o: registered, same cycle as cnt_q. clk_o = en & (cnt_q < D>>1).
  - Even D gives a 50% duty cycle.
  - Odd D gives high for floor(D/2) of every D cycles.
  - First high phase begins at cnt_q=0 after enable.
- Handshake: a transfer occurs when div_valid_i & div_ready_o.
  - div_ready_o = (state != LOAD).
  - div_done_o = (state == RUN).
- FSM:
  - RUN: on a transfer, pend_q <= clamp(div_i), go to PEND. div_done_o is low from the next cycle.
  - PEND: the old divisor keeps running.
    - A transfer in PEND overwrites pend_q (last write wins); stay in PEND.
    - Boundary condition: (en_i & cnt_q==D-1) or en_i==0. On it: div_q <= pend_q, cnt_q <= 0, go to LOAD.
  - LOAD: one cycle with the new D already counting (cnt_q=0). div_ready_o=0, div_done_o=0; unconditionally go to RUN.
  - div_valid_i during LOAD is ignored, not accepted.
- Simultaneous events:
  - A transfer in RUN on the same cycle as terminal count: the current tick still fires; the new divisor applies at the following boundary, not this one.
  - A transfer in PEND on the boundary cycle: the new div_i is the value loaded (the write wins over pend_q).
- Latency:
  - With en_i=0, the new divisor is active 2 cycles after the transfer (PEND then LOAD).
  - Otherwise the change waits up to D_old cycles.
- Period continuity: no period is shortened or stretched. The last old period is exactly D_old cycles; the first new period is exactly D_new cycles.
- cnt_o = cnt_q.

Test Plan:
- Reset: rst_n_i low 3 cycles with en_i=1 -> cnt_o=0, tick_o=0, clk_o=0, div_ready_o=1, div_done_o=1. Release -> tick_o every 2 cycles; clk_o toggles 1,0,1,0.
- Divisor 5: write div_i=5 with en_i=0 -> PEND one cycle, LOAD one cycle, div_done_o=1 on the 3rd cycle. Enable -> tick_o once per 5 cycles, clk_o high 2 of every 5 cycles.
- Glitch-free change: running D=8 with cnt_o=3, write div_i=4 -> old period completes (4 more cycles, tick at cnt 7). Next ticks every 4 cycles; div_done_o low from 1 cycle after the transfer until LOAD ends.
- Clamping and overwrite: in PEND, write div_i=1 then div_i=0 -> D=2 after the boundary; tick every 2 cycles.
- Boundary collision: D=6, assert div_valid_i with div_i=3 on the cycle cnt_o=5 -> tick fires; the following period is still 6; then period 3.
- Reset mid-change: reset asserted in PEND with pend_q=10 -> D returns to DEF_DIV=2, state=RUN, div_done_o=1.

Source files
------------

// File: rtl/clk_int_div_tick.sv
// ----------------------------------------------------------------------------
// clk_int_div_tick
//
// Runtime-programmable integer prescaler feeding the APB timer counter.
// Divides clk_i by a software-written divisor D and produces:
//   - tick_o : a one-cycle enable, once per divided period
//   - clk_o  : a registered divided clock (floor(D/2) high cycles per period)
//   - cnt_o  : the current phase counter, for debug and readback
//
// A new divisor is requested through a valid/ready handshake. It is staged
// in pend_q and only swapped into div_q on a period boundary. This way the
// downstream counter never sees a shortened or stretched period.
//
// FSM:
//   RUN  - the divisor in effect is the last one accepted (done=1)
//   PEND - a new divisor is staged, the old one keeps running until the
//          boundary; further writes overwrite the staged value
//   LOAD - one cycle with the new divisor already counting from 0;
//          writes are refused (ready=0)
// ----------------------------------------------------------------------------
module clk_int_div_tick #(
    parameter int unsigned DIV_WIDTH = 20,
    parameter int unsigned DEF_DIV   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 div_done_o,
    output logic                 tick_o,
    output logic                 clk_o,
    output logic [DIV_WIDTH-1:0] cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [DIV_WIDTH-1:0] ZERO      = '0;
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] DEF_DIV_V = DIV_WIDTH'(DEF_DIV);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Divisors of 0 and 1 cannot produce a one-cycle tick followed by a low
    // cycle, so they are raised to the smallest meaningful divisor.
    // ------------------------------------------------------------------------
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q,   div_d;    // divisor currently in effect
    logic [DIV_WIDTH-1:0] pend_q,  pend_d;   // staged divisor awaiting boundary
    logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;    // phase within the current period
    logic                 tick_q,  tick_d;
    logic                 clk_q,   clk_d;

    // ------------------------------------------------------------------------
    // Handshake and period-boundary qualifiers
    // ------------------------------------------------------------------------
    logic                 ready;
    logic                 transfer;
    logic                 terminal;   // last cycle of the current period
    logic                 boundary;   // safe point to swap the divisor
    logic [DIV_WIDTH-1:0] req_div;    // clamped request value

    assign ready    = (state_q != ST_LOAD);
    assign transfer = div_valid_i & ready;
    assign req_div  = clamp_div(div_i);
    assign terminal = (cnt_q == div_q - ONE);
    // An idle divider has no period in flight, so any cycle is a boundary.
    assign boundary = ~en_i | terminal;

    // Next-state logic for the FSM, divisor staging, counter and outputs
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;

        unique case (state_q)
            ST_RUN: begin
                // A write on the terminal cycle is only staged here; the
                // period it lands in still completes with the old divisor.
                if (transfer) begin
                    pend_d  = req_div;
                    state_d = ST_PEND;
                end
            end

            ST_PEND: begin
                // Last write wins, including one that lands on the boundary.
                if (transfer) begin
                    pend_d = req_div;
                end
                if (boundary) begin
                    div_d   = pend_d;
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Counter: free-runs 0..D-1 while enabled, parks at 0 while idle.
        // A divisor swap always coincides with the wrap to 0, so the first
        // period under the new divisor starts cleanly.
        if (!en_i || terminal) begin
            cnt_d = ZERO;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // Outputs are derived from the next count and next divisor so that
        // they are registered in the same cycle as cnt_q.
        tick_d = en_i & (cnt_d == div_d - ONE);
        clk_d  = en_i & (cnt_d < (div_d >> 1));
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n_i) begin
            state_q <= ST_RUN;
            div_q   <= DEF_DIV_V;
            pend_q  <= DEF_DIV_V;
            cnt_q   <= ZERO;
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign div_ready_o = ready;
    assign div_done_o  = (state_q == ST_RUN);
    assign tick_o      = tick_q;
    assign clk_o       = clk_q;
    assign cnt_o       = cnt_q;

endmodule
